// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types, widths and helpers for the multiply/divide unit
//
// Holds the FSM state encoding, the operand width, the iteration count and
// the counter width used by muldiv_unit and muldiv_iter_counter.

package muldiv_pkg;

    localparam int DATA_W     = 32;
    localparam int ITER_COUNT = 32;
    // One bit wider than log2(ITER_COUNT) so the counter can rest at ITER_COUNT.
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Magnitude of a two's-complement word; 0x80000000 maps to 2^31,
    // which is still representable as an unsigned 32-bit value.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/muldiv_iter_counter.sv
// rtl/muldiv_iter_counter.sv - iteration counter with clear, enable and terminal count
//
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous active-low reset
//   clear   - synchronous clear to zero (priority over enable)
//   enable  - advance by one per cycle, saturating at ITER_COUNT
//   tc      - high while the count equals ITER_COUNT-1 (last iteration)

module muldiv_iter_counter
    import muldiv_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != CNT_W'(ITER_COUNT))) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == CNT_W'(ITER_COUNT - 1));

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed 32-bit multiply / divide unit
//
// Ports:
//   clock          - rising-edge clock
//   reset          - asynchronous active-low reset
//   data_operandA  - signed multiplicand / dividend, sampled on the start edge
//   data_operandB  - signed multiplier / divisor, sampled on the start edge
//   ctrl_MULT      - one-cycle multiply start (wins if ctrl_DIV is also high)
//   ctrl_DIV       - one-cycle divide start
//   data_result    - product low word or quotient, held until the next completion
//   data_exception - multiply overflow, divide by zero, or MIN / -1
//   data_resultRDY - one-cycle completion strobe
//   busy           - high while an operation is in flight
//
// Build option: MULDIV_EARLY_DIV0_EN - a divide by zero completes one cycle
// after its start instead of running the full 32 iterations.

module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_operandA,
    input  logic [DATA_W-1:0] data_operandB,
    input  logic              ctrl_MULT,
    input  logic              ctrl_DIV,
    output logic [DATA_W-1:0] data_result,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic              busy
);

    state_e            state_q,  state_d;
    logic [DATA_W-1:0] a_mag_q,  a_mag_d;   // |A|, added into the product
    logic [DATA_W-1:0] b_mag_q,  b_mag_d;   // |B|, divisor magnitude
    logic              neg_q,    neg_d;     // sign to apply at completion
    logic              b_zero_q, b_zero_d;
    logic              dovf_q,   dovf_d;    // 0x80000000 / -1
    // hi: product high word (multiply) or signed partial remainder (divide).
    // lo: multiplier bits shifting out (multiply) or dividend bits shifting
    //     out while quotient bits shift in (divide).
    logic [DATA_W:0]   hi_q,     hi_d;
    logic [DATA_W-1:0] lo_q,     lo_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              exc_q,    exc_d;
    logic              rdy_q,    rdy_d;
    logic              busy_q,   busy_d;

    logic cnt_clear;
    logic cnt_en;
    logic cnt_tc;
    logic early_done;

    muldiv_iter_counter u_iter_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .tc     (cnt_tc)
    );

`ifdef MULDIV_EARLY_DIV0_EN
    assign early_done = b_zero_q;
`else
    assign early_done = 1'b0;
`endif

    // One shift-add multiply step: add |A| when the current multiplier bit is
    // set, then shift the 65-bit {carry, hi, lo} right by one.
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     mul_hi_nxt;
    logic [DATA_W-1:0]   mul_lo_nxt;
    logic [2*DATA_W-1:0] product;
    logic [2*DATA_W-1:0] prod_signed;
    logic [DATA_W:0]     prod_top;
    logic                mul_ovf;

    // One non-restoring divide step: shift the next dividend bit into the
    // remainder, subtract the divisor if the remainder is non-negative, add it
    // back otherwise; the new quotient bit is the inverted remainder sign.
    // The quotient needs no correction; only the remainder would, and it is
    // discarded.
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_r_nxt;
    logic [DATA_W-1:0]   div_lo_nxt;
    logic [DATA_W-1:0]   quot_signed;

    always_comb begin
        mul_sum    = {1'b0, hi_q[DATA_W-1:0]} + (lo_q[0] ? {1'b0, a_mag_q} : '0);
        mul_hi_nxt = {1'b0, mul_sum[DATA_W:1]};
        mul_lo_nxt = {mul_sum[0], lo_q[DATA_W-1:1]};
        product    = {mul_hi_nxt[DATA_W-1:0], mul_lo_nxt};
        prod_signed = neg_q ? (~product + {{(2*DATA_W-1){1'b0}}, 1'b1}) : product;
        // Overflow when the signed product does not sign-extend from bit 31.
        prod_top   = prod_signed[2*DATA_W-1:DATA_W-1];
        mul_ovf    = !((prod_top == '0) || (prod_top == '1));

        div_shift  = {hi_q[DATA_W-1:0], lo_q[DATA_W-1]};
        div_r_nxt  = hi_q[DATA_W] ? (div_shift + {1'b0, b_mag_q})
                                  : (div_shift - {1'b0, b_mag_q});
        div_lo_nxt = {lo_q[DATA_W-2:0], ~div_r_nxt[DATA_W]};
        quot_signed = neg_q ? (~div_lo_nxt + {{(DATA_W-1){1'b0}}, 1'b1}) : div_lo_nxt;
    end

    always_comb begin
        state_d   = state_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        neg_d     = neg_q;
        b_zero_d  = b_zero_q;
        dovf_d    = dovf_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        exc_d     = exc_q;
        rdy_d     = 1'b0;
        busy_d    = busy_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (ctrl_MULT || ctrl_DIV) begin
                    state_d   = ctrl_MULT ? ST_MUL : ST_DIV;
                    busy_d    = 1'b1;
                    cnt_clear = 1'b1;
                    a_mag_d   = abs_val(data_operandA);
                    b_mag_d   = abs_val(data_operandB);
                    neg_d     = data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
                    b_zero_d  = (data_operandB == '0);
                    dovf_d    = (data_operandA == {1'b1, {(DATA_W-1){1'b0}}}) &&
                                (data_operandB == '1);
                    hi_d      = '0;
                    lo_d      = ctrl_MULT ? abs_val(data_operandB)
                                          : abs_val(data_operandA);
                end
            end

            ST_MUL: begin
                cnt_en = 1'b1;
                hi_d   = mul_hi_nxt;
                lo_d   = mul_lo_nxt;
                if (cnt_tc) begin
                    state_d  = ST_DONE;
                    rdy_d    = 1'b1;
                    busy_d   = 1'b0;
                    result_d = prod_signed[DATA_W-1:0];
                    exc_d    = mul_ovf;
                end
            end

            ST_DIV: begin
                cnt_en = 1'b1;
                hi_d   = div_r_nxt;
                lo_d   = div_lo_nxt;
                if (cnt_tc || early_done) begin
                    state_d  = ST_DONE;
                    rdy_d    = 1'b1;
                    busy_d   = 1'b0;
                    // MIN / -1 already yields 0x80000000 from the magnitude path.
                    result_d = b_zero_q ? '0 : quot_signed;
                    exc_d    = b_zero_q | dovf_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            neg_q    <= 1'b0;
            b_zero_q <= 1'b0;
            dovf_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            neg_q    <= neg_d;
            b_zero_q <= b_zero_d;
            dovf_q   <= dovf_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 clock  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, released synchronously to clock.
REQ-003 data_operandA  input  32  signed two's-complement multiplicand / dividend.
REQ-004 data_operandB  input  32  signed two's-complement multiplier / divisor.
REQ-005 ctrl_MULT  input  1  one-cycle start pulse, multiply.
REQ-006 ctrl_DIV  input  1  one-cycle start pulse, divide.
REQ-007 data_result  output  32  product low word or quotient.
REQ-008 data_exception  output  1  overflow / divide-by-zero flag; feeds overflow control as muldiv_ovf.
REQ-009 data_resultRDY  output  1  one-cycle completion strobe.
REQ-010 busy  output  1  high while an operation is in flight; the stall unit holds D/X while high.

Function
REQ-011 States SHALL be IDLE, MUL, DIV, DONE.
REQ-012 A start SHALL be accepted only in IDLE or DONE: operands latched, counter cleared, next state MUL (ctrl_MULT) or DIV (ctrl_DIV).
REQ-013 ctrl_MULT and ctrl_DIV high together SHALL start a multiply; ctrl_DIV is ignored.
REQ-014 Starts seen in MUL or DIV SHALL be ignored with no effect on the current operation.
REQ-015 Operand inputs SHALL be don't-care after the start edge.
REQ-016 Multiply SHALL be radix-2 shift-add over 32 iterations on magnitudes, with sign applied at completion, producing a 64-bit product.
REQ-017 Divide SHALL be non-restoring over 32 iterations on magnitudes; quotient sign = signA XOR signB; remainder discarded; quotient truncates toward zero.
REQ-018 Start at edge k SHALL move the FSM to DONE at edge k+32; data_resultRDY high for exactly the cycle between edges k+32 and k+33.
REQ-019 DONE SHALL return to IDLE on the next edge unless a new start is present (back-to-back allowed, next RDY at +32).
REQ-020 busy SHALL be high in MUL and DIV, low in IDLE and DONE.
REQ-021 Multiply overflow: data_exception=1 when the 64-bit product does not sign-extend from bit 31; data_result = low 32 bits.
REQ-022 Divide by zero (B=0): data_exception=1, data_result=0.
REQ-023 Divide 0x80000000 by 0xFFFFFFFF: data_exception=1, data_result=0x80000000.
REQ-024 data_result and data_exception SHALL update only on entry to DONE and hold until the next DONE entry.
REQ-025 Counter SHALL be 6 bits; terminal count 31 triggers the DONE transition; no wrap beyond 32.

Reset
REQ-026 Reset low SHALL force IDLE, counter 0, data_result 0, data_exception 0, data_resultRDY 0, busy 0.
REQ-027 Reset asserted mid-operation SHALL abort it; no RDY strobe for the aborted operation after release.

Configuration
REQ-028 With MULDIV_EARLY_DIV0_EN defined, a divide with B=0 SHALL go to DONE at edge k+1 (RDY one cycle after start, exception=1, result=0).
REQ-029 Without MULDIV_EARLY_DIV0_EN, divide-by-zero SHALL take the full 32-cycle latency with the same result and exception.

Structure
REQ-030 Package muldiv_pkg SHALL hold the state enum, the data width constant (32) and the iteration count constant (32).
REQ-031 The iteration counter SHALL be a sub-module, muldiv_iter_counter (clear, enable, terminal-count output).

Verification
REQ-032 MULT 7 x -6 at edge k -> RDY only at k+32, result 0xFFFFFFD6, exception 0, busy high k..k+32.
REQ-033 MULT 0x00010000 x 0x00010000 -> result 0x00000000, exception 1.
REQ-034 DIV -7 / 2 -> result 0xFFFFFFFD, exception 0; DIV 0x80000000 / -1 -> result 0x80000000, exception 1.
REQ-035 DIV 5 / 0 -> result 0, exception 1; RDY at k+1 with MULDIV_EARLY_DIV0_EN, at k+32 without.
REQ-036 ctrl_MULT pulse at k+10 during a DIV -> ignored, DIV result unchanged; new start in the DONE cycle -> second RDY exactly 32 cycles later.
REQ-037 Reset low at k+15 of a MULT -> outputs 0 immediately; after release, no RDY and IDLE until the next start.
